// File: rtl/fb_write_scheduler.sv
// fb_write_scheduler
// Round-robin arbiter sharing the frame-buffer RAM write port between
// NUM_REQ pixel writers. Requests are (x, y) coordinates that map to the
// linear address y*H_RES + x; out-of-range coordinates are accepted and
// dropped. A clear engine fills the whole buffer with one value on command.
// All RAM-side outputs are registered, one cycle after the accepting cycle.
//
// Optional build feature, enabled by defining FB_WR_DROP_CNT_EN:
//   adds drop_count (saturating count of dropped requests) and drop_clr.
module fb_write_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*10-1:0]      req_x,
  input  logic [NUM_REQ*9-1:0]       req_y,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic                       clear_start,
  input  logic [DATA_W-1:0]          clear_value,
  output logic                       busy,
  output logic                       clear_done,
  output logic                       wr_en,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [DATA_W-1:0]          wr_data
`ifdef FB_WR_DROP_CNT_EN
  ,
  input  logic                       drop_clr,
  output logic [15:0]                drop_count
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state, state_next;
  logic [PTR_W-1:0]  ptr, ptr_next;
  logic [ADDR_W-1:0] cnt, cnt_next;
  logic [DATA_W-1:0] clr_val, clr_val_next;

  logic              wr_en_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [DATA_W-1:0] wr_data_d;
  logic              clear_done_d;

  logic              gnt_found;
  logic [PTR_W-1:0]  gnt_idx;
  logic [PTR_W-1:0]  cand;
  logic [9:0]        sel_x;
  logic [8:0]        sel_y;
  logic [DATA_W-1:0] sel_data;
  logic              in_range;

  // Round-robin search: first valid requester at or above the pointer, wrapping.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no path can leave it unassigned and infer a latch.
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr) + k >= NUM_REQ) ? PTR_W'(int'(ptr) + k - NUM_REQ)
                                         : PTR_W'(int'(ptr) + k);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Pick out the granted requester's fields and range-check the coordinates.
  always_comb begin
    sel_x    = req_x[int'(gnt_idx) * 10 +: 10];
    sel_y    = req_y[int'(gnt_idx) * 9 +: 9];
    sel_data = req_data[int'(gnt_idx) * DATA_W +: DATA_W];
    in_range = (32'(sel_x) < 32'(H_RES)) && (32'(sel_y) < 32'(V_RES));
  end

  // Next-state, handshake and next-cycle write decode for both states.
  always_comb begin
    state_next   = state;
    ptr_next     = ptr;
    cnt_next     = cnt;
    clr_val_next = clr_val;
    req_ready    = '0;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr;
    wr_data_d    = wr_data;
    clear_done_d = 1'b0;
    case (state)
      ARB: begin
        if (clear_start) begin
          // Clear outranks requesters: nobody is accepted in this cycle.
          state_next   = CLEAR;
          clr_val_next = clear_value;
        end else if (gnt_found) begin
          req_ready[gnt_idx] = 1'b1;
          ptr_next = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          if (in_range) begin
            // Product formed at 32 bits, then truncated to the RAM address width.
            wr_en_d   = 1'b1;
            wr_addr_d = ADDR_W'(32'(sel_y) * 32'(H_RES) + 32'(sel_x));
            wr_data_d = sel_data;
          end
        end
      end
      CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt;
        wr_data_d = clr_val;
        if (cnt == LAST_ADDR) begin
          state_next   = ARB;
          cnt_next     = '0;
          clear_done_d = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = ARB;
    endcase
  end

  // State, pointer, clear counter and registered RAM-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB;
      ptr        <= '0;
      cnt        <= '0;
      clr_val    <= '0;
      busy       <= 1'b0;
      clear_done <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register update from pre-edge values, independent of statement order.
      state      <= state_next;
      ptr        <= ptr_next;
      cnt        <= cnt_next;
      clr_val    <= clr_val_next;
      busy       <= (state_next == CLEAR);
      clear_done <= clear_done_d;
      wr_en      <= wr_en_d;
      wr_addr    <= wr_addr_d;
      wr_data    <= wr_data_d;
    end
  end

`ifdef FB_WR_DROP_CNT_EN
  logic drop_inc;
  assign drop_inc = (state == ARB) && !clear_start && gnt_found && !in_range;

  // Saturating count of accepted-but-dropped requests; clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count <= '0;
    end else if (drop_clr) begin
      drop_count <= '0;
    end else if (drop_inc && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fb_write_scheduler.sv
// tb_fb_write_scheduler
// Self-checking bench for fb_write_scheduler using a reduced 40x30 frame and
// three requesters. A behavioural model (round-robin scan with modulo
// arithmetic, y*H+x mapping) predicts grants and write outputs.
// Connects drop_clr/drop_count when FB_WR_DROP_CNT_EN is defined.
module tb_fb_write_scheduler;

  localparam int NR = 3;
  localparam int H  = 40;
  localparam int V  = 30;
  localparam int AW = 11;
  localparam int DW = 8;
  localparam int NPIX = H * V;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR*10-1:0]  req_x = '0;
  logic [NR*9-1:0]   req_y = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic              clear_start = 1'b0;
  logic [DW-1:0]     clear_value = '0;
  logic              busy, clear_done, wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
`ifdef FB_WR_DROP_CNT_EN
  logic              drop_clr = 1'b0;
  logic [15:0]       drop_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: pointer, expected ready and expected registered outputs.
  int            m_ptr = 0;
  logic [NR-1:0] exp_rdy = '0;
  logic          m_wr_en = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  int            m_drop = 0;

  fb_write_scheduler #(
    .NUM_REQ(NR), .H_RES(H), .V_RES(V), .ADDR_W(AW), .DATA_W(DW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_data(req_data),
    .clear_start(clear_start), .clear_value(clear_value),
    .busy(busy), .clear_done(clear_done),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
`ifdef FB_WR_DROP_CNT_EN
    , .drop_clr(drop_clr), .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  // Apply one cycle of requests and advance the model to its post-edge view.
  task automatic model_step(input logic [NR-1:0] v, input logic [NR*10-1:0] xs,
                            input logic [NR*9-1:0] ys, input logic [NR*DW-1:0] ds);
    int g;
    int x;
    int y;
    g = -1;
    for (int k = 0; k < NR; k++)
      if (g < 0 && v[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
    exp_rdy = '0;
    m_wr_en = 1'b0;
    if (g >= 0) begin
      exp_rdy[g] = 1'b1;
      x = int'(xs[g*10 +: 10]);
      y = int'(ys[g*9 +: 9]);
      if (x < H && y < V) begin
        m_wr_en = 1'b1;
        m_addr  = AW'((y * H + x) % (1 << AW));
        m_data  = ds[g*DW +: DW];
      end else if (m_drop < 65535) begin
        m_drop++;
      end
      m_ptr = (g + 1) % NR;
    end
    req_valid = v;
    req_x = xs;
    req_y = ys;
    req_data = ds;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({wr_en, wr_addr, wr_data, busy, clear_done} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got en=%b addr=%0d data=%h busy=%b done=%b, want all 0",
               wr_en, wr_addr, wr_data, busy, clear_done);
    end
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if (req_ready !== '0) begin
      n_err++;
      $display("FAIL reset_ready: got %b want 000", req_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_write();
    model_step(3'b001, {10'd0, 10'd0, 10'd3}, {9'd0, 9'd0, 9'd2}, {8'h00, 8'h00, 8'hAA});
    @(negedge clk);
    n_vec++;
    if (req_ready !== 3'b001) begin
      n_err++;
      $display("FAIL single_ready: got %b want 001", req_ready);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, AW'(2 * H + 3), 8'hAA}) begin
      n_err++;
      $display("FAIL single_write: got en=%b addr=%0d data=%h want en=1 addr=%0d data=aa",
               wr_en, wr_addr, wr_data, 2 * H + 3);
    end
    model_step(3'b000, '0, '0, '0);
    @(posedge clk);
    #1;
    n_vec++;
    if ({wr_en, wr_addr, wr_data} !== {1'b0, m_addr, m_data}) begin
      n_err++;
      $display("FAIL idle_hold: got en=%b addr=%0d data=%h want en=0 addr=%0d data=%h",
               wr_en, wr_addr, wr_data, m_addr, m_data);
    end
  endtask

  task automatic test_round_robin();
    logic [NR*10-1:0] xs;
    logic [NR*9-1:0]  ys;
    logic [NR*DW-1:0] ds;
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < NR; i++) begin
        xs[i*10 +: 10] = 10'($urandom_range(0, H - 1));
        ys[i*9 +: 9]   = 9'($urandom_range(0, V - 1));
        ds[i*DW +: DW] = DW'($urandom);
      end
      model_step((c < 6) ? 3'b011 : 3'b100, xs, ys, ds);
      @(negedge clk);
      n_vec++;
      if (req_ready !== exp_rdy) begin
        n_err++;
        $display("FAIL rr_ready c=%0d: got %b want %b", c, req_ready, exp_rdy);
      end
      @(posedge clk);
      #1;
      n_vec++;
      if ({wr_en, wr_addr, wr_data} !== {1'b1, m_addr, m_data}) begin
        n_err++;
        $display("FAIL rr_write c=%0d: got en=%b addr=%0d data=%h want en=1 addr=%0d data=%h",
                 c, wr_en, wr_addr, wr_data, m_addr, m_data);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [NR*10-1:0] xs [3];
    logic [NR*9-1:0]  ys [3];
    xs[0] = {10'd0, 10'(H), 10'd0};     ys[0] = {9'd0, 9'd0, 9'd0};
    xs[1] = {10'd0, 10'd5, 10'd0};      ys[1] = {9'd0, 9'(V), 9'd0};
    xs[2] = {10'd0, 10'd1023, 10'd0};   ys[2] = {9'd0, 9'd0, 9'd0};
    for (int c = 0; c < 3; c++) begin
      model_step(3'b010, xs[c], ys[c], {8'h00, 8'h5C, 8'h00});
`ifdef FB_WR_DROP_CNT_EN
      drop_clr = (c == 2);
      if (c == 2) m_drop = 0;
`endif
      @(negedge clk);
      n_vec++;
      if (req_ready !== exp_rdy) begin
        n_err++;
        $display("FAIL oor_ready c=%0d: got %b want %b", c, req_ready, exp_rdy);
      end
      @(posedge clk);
      #1;
      n_vec++;
      if ({wr_en, wr_addr, wr_data} !== {1'b0, m_addr, m_data}) begin
        n_err++;
        $display("FAIL oor_nowrite c=%0d: got en=%b addr=%0d data=%h want en=0 addr=%0d data=%h",
                 c, wr_en, wr_addr, wr_data, m_addr, m_data);
      end
`ifdef FB_WR_DROP_CNT_EN
      drop_clr = 1'b0;
      n_vec++;
      if (int'(drop_count) != m_drop) begin
        n_err++;
        $display("FAIL drop_count c=%0d: got %0d want %0d", c, drop_count, m_drop);
      end
`endif
    end
  endtask

  task automatic test_random();
    logic [NR*10-1:0] xs;
    logic [NR*9-1:0]  ys;
    logic [NR*DW-1:0] ds;
    logic [NR-1:0]    v;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        xs[i*10 +: 10] = 10'($urandom_range(0, H + 6));
        ys[i*9 +: 9]   = 9'($urandom_range(0, V + 4));
        ds[i*DW +: DW] = DW'($urandom);
      end
      v = NR'($urandom);
      model_step(v, xs, ys, ds);
      @(negedge clk);
      n_vec++;
      if (req_ready !== exp_rdy) begin
        n_err++;
        $display("FAIL rand_ready c=%0d: got %b want %b", c, req_ready, exp_rdy);
      end
      @(posedge clk);
      #1;
      n_vec++;
      if ({wr_en, wr_addr, wr_data, busy, clear_done} !== {m_wr_en, m_addr, m_data, 2'b00}) begin
        n_err++;
        $display("FAIL rand_write c=%0d: got en=%b addr=%0d data=%h busy=%b done=%b want en=%b addr=%0d data=%h busy=0 done=0",
                 c, wr_en, wr_addr, wr_data, busy, clear_done, m_wr_en, m_addr, m_data);
      end
    end
  endtask

  // Full clear with requester 0 waiting; checks sequence, flags and the hand-back.
  task automatic test_clear_full();
    int writes = 0;
    int seq_bad = 0;
    int busy_bad = 0;
    int low = 0;
    bit done_seen = 1'b0;
    req_valid = 3'b001;
    req_x = {10'd0, 10'd0, 10'd5};
    req_y = {9'd0, 9'd0, 9'd1};
    req_data = {8'h00, 8'h00, 8'h77};
    clear_start = 1'b1;
    clear_value = 8'h10;
    @(negedge clk);
    if (req_ready === '0) low++;
    @(posedge clk);
    #1;
    clear_start = 1'b0;
    clear_value = 8'hEE;
    n_vec++;
    if ({busy, wr_en, clear_done} !== 3'b100) begin
      n_err++;
      $display("FAIL clear_enter: got busy=%b en=%b done=%b want busy=1 en=0 done=0",
               busy, wr_en, clear_done);
    end
    for (int t = 0; t < NPIX + 8 && !done_seen; t++) begin
      @(negedge clk);
      if (req_ready === '0) low++;
      @(posedge clk);
      #1;
      if (wr_en === 1'b1) begin
        if (wr_addr !== AW'(writes) || wr_data !== 8'h10) seq_bad++;
        writes++;
      end else begin
        seq_bad++;
      end
      if (clear_done === 1'b1) begin
        done_seen = 1'b1;
        if (busy !== 1'b0 || wr_addr !== AW'(NPIX - 1)) busy_bad++;
      end else if (busy !== 1'b1) begin
        busy_bad++;
      end
    end
    n_vec++;
    if (!done_seen || writes != NPIX) begin
      n_err++;
      $display("FAIL clear_count: got %0d writes done=%b want %0d writes done=1", writes, done_seen, NPIX);
    end
    n_vec++;
    if (seq_bad != 0) begin
      n_err++;
      $display("FAIL clear_sequence: got %0d bad cycles want 0", seq_bad);
    end
    n_vec++;
    if (busy_bad != 0) begin
      n_err++;
      $display("FAIL clear_busy_done: got %0d flag errors want 0", busy_bad);
    end
    n_vec++;
    if (low != NPIX + 1) begin
      n_err++;
      $display("FAIL clear_ready_low: got %0d cycles want %0d", low, NPIX + 1);
    end
    m_addr = AW'(NPIX - 1);
    m_data = 8'h10;
    model_step(3'b001, req_x, req_y, req_data);
    @(negedge clk);
    n_vec++;
    if (req_ready !== 3'b001) begin
      n_err++;
      $display("FAIL clear_handback_ready: got %b want 001", req_ready);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if ({wr_en, wr_addr, wr_data, busy, clear_done} !== {1'b1, AW'(H + 5), 8'h77, 2'b00}) begin
      n_err++;
      $display("FAIL clear_handback_write: got en=%b addr=%0d data=%h busy=%b done=%b want en=1 addr=%0d data=77 busy=0 done=0",
               wr_en, wr_addr, wr_data, busy, clear_done, H + 5);
    end
  endtask

  // Second clear_start mid-clear must be ignored; pointer survives the clear.
  task automatic test_clear_restart();
    int writes = 0;
    int seq_bad = 0;
    bit done_seen = 1'b0;
    logic [NR*10-1:0] xs;
    logic [NR*9-1:0]  ys;
    logic [NR*DW-1:0] ds;
    xs = {10'd9, 10'd8, 10'd7};
    ys = {9'd3, 9'd2, 9'd1};
    ds = {8'hC3, 8'hB2, 8'hA1};
    req_valid = 3'b111;
    req_x = xs;
    req_y = ys;
    req_data = ds;
    clear_start = 1'b1;
    clear_value = 8'h3C;
    @(posedge clk);
    #1;
    clear_start = 1'b0;
    for (int t = 0; t < NPIX + 8 && !done_seen; t++) begin
      clear_start = (t == NPIX / 2);
      clear_value = 8'h99;
      @(posedge clk);
      #1;
      if (wr_en === 1'b1) begin
        if (wr_addr !== AW'(writes) || wr_data !== 8'h3C) seq_bad++;
        writes++;
      end
      if (clear_done === 1'b1) done_seen = 1'b1;
    end
    clear_start = 1'b0;
    n_vec++;
    if (!done_seen || writes != NPIX || seq_bad != 0) begin
      n_err++;
      $display("FAIL restart_ignored: got %0d writes %0d bad done=%b want %0d writes 0 bad done=1",
               writes, seq_bad, done_seen, NPIX);
    end
    m_addr = AW'(NPIX - 1);
    m_data = 8'h3C;
    model_step(3'b111, xs, ys, ds);
    @(negedge clk);
    n_vec++;
    if (req_ready !== exp_rdy) begin
      n_err++;
      $display("FAIL ptr_kept: got %b want %b", req_ready, exp_rdy);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if ({wr_en, wr_addr, wr_data} !== {m_wr_en, m_addr, m_data}) begin
      n_err++;
      $display("FAIL ptr_kept_write: got en=%b addr=%0d data=%h want en=%b addr=%0d data=%h",
               wr_en, wr_addr, wr_data, m_wr_en, m_addr, m_data);
    end
    model_step(3'b000, '0, '0, '0);
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset at clear address 1000 abandons the clear.
  task automatic test_reset_mid_clear();
    bit found = 1'b0;
    clear_start = 1'b1;
    clear_value = 8'h5A;
    @(posedge clk);
    #1;
    clear_start = 1'b0;
    for (int t = 0; t < NPIX + 8 && !found; t++) begin
      @(posedge clk);
      #1;
      if (wr_en === 1'b1 && wr_addr === AW'(1000)) found = 1'b1;
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL reach_addr_1000: got no write to 1000 within %0d cycles", NPIX + 8);
    end
    #1;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({wr_en, busy, clear_done, wr_addr, wr_data} !== '0) begin
      n_err++;
      $display("FAIL async_reset: got en=%b busy=%b done=%b addr=%0d data=%h want all 0",
               wr_en, busy, clear_done, wr_addr, wr_data);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    m_wr_en = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_drop = 0;
    @(posedge clk);
    #1;
    n_vec++;
    if ({wr_en, busy, clear_done} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_no_resume: got en=%b busy=%b done=%b want 0 0 0", wr_en, busy, clear_done);
    end
    model_step(3'b110, {10'd2, 10'd7, 10'd0}, {9'd4, 9'd3, 9'd0}, {8'h44, 8'h3E, 8'h00});
    @(negedge clk);
    n_vec++;
    if (req_ready !== 3'b010) begin
      n_err++;
      $display("FAIL post_reset_ready: got %b want 010", req_ready);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, AW'(3 * H + 7), 8'h3E}) begin
      n_err++;
      $display("FAIL post_reset_write: got en=%b addr=%0d data=%h want en=1 addr=%0d data=3e",
               wr_en, wr_addr, wr_data, 3 * H + 7);
    end
    model_step(3'b000, '0, '0, '0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_out_of_range();
    test_random();
    test_clear_full();
    test_clear_restart();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fb_write_scheduler.md
Name: fb_write_scheduler

Overview:
- Shares the single write port of the frame-buffer RAM between NUM_REQ pixel writers, such as a drawing engine and a test-pattern source. Arbitration is round-robin.
- Maps (x, y) to the linear address y*H_RES + x and drops out-of-range coordinates.
- Contains a clear engine that fills the whole buffer with one value on command.
- Sits in the system-clock domain, directly in front of the RAM write port. The read side stays with the display timing logic.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- H_RES, 640, visible pixels per line
- V_RES, 480, visible lines per frame
- ADDR_W, 19, RAM address width; must satisfy 2^ADDR_W >= H_RES*V_RES
- DATA_W, 8, pixel width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  NUM_REQ  per-requester write request
- req_ready  out  NUM_REQ  per-requester accept (combinational)
- req_x  in  NUM_REQ*10  x coordinate, requester i in bits [10i+9:10i]
- req_y  in  NUM_REQ*9  y coordinate, requester i in bits [9i+8:9i]
- req_data  in  NUM_REQ*DATA_W  pixel value
- clear_start  in  1  single-cycle request to clear the buffer
- clear_value  in  DATA_W  fill value, sampled together with clear_start
- busy  out  1  high while the clear engine is running
- clear_done  out  1  one-cycle pulse marking the final clear write
- wr_en  out  1  RAM write enable
- wr_addr  out  ADDR_W  RAM write address
- wr_data  out  DATA_W  RAM write data

Behaviour:
- Reset values: state ARB, round-robin pointer 0, clear counter 0. Outputs busy, clear_done, wr_en, wr_addr and wr_data are all 0.
- Two states: ARB and CLEAR.
- ARB arbitration:
  - The grant goes to the first i with req_valid[i]=1, searching from the pointer upward and wrapping modulo NUM_REQ.
  - req_ready[i]=1 only for the granted i; all other req_ready bits are 0.
  - A transfer occurs when req_valid[i] and req_ready[i] are both high. At most one transfer per cycle.
  - After a transfer by i, the pointer becomes (i+1) mod NUM_REQ. With no transfer, the pointer holds.
- Write latency:
  - The cycle after a transfer, wr_en=1, wr_addr=y*H_RES+x and wr_data=req_data[i]. All three are registered outputs.
  - The address product is computed at full width, then truncated to ADDR_W.
- Out-of-range requests (x>=H_RES or y>=V_RES): still accepted (ready=1, pointer advances), but no write is issued; wr_en stays 0 the next cycle.
- With no transfer, wr_en=0 the next cycle; wr_addr and wr_data hold their last values.
- clear_start in ARB:
  - clear_value is latched and the block enters CLEAR next cycle. busy rises with the state change.
  - In the clear_start cycle, req_ready is all 0; clear takes priority over requesters.
- CLEAR sequence:
  - req_ready is all 0 throughout.
  - Each cycle the counter value c (0 .. H_RES*V_RES-1) is issued, giving registered wr_en=1, wr_addr=c, wr_data=latched value one cycle later.
  - When c reaches H_RES*V_RES-1, the block returns to ARB and the counter clears.
  - clear_done pulses in the same cycle that wr_en presents the last address. busy falls in that same cycle.
- Clear throughput: exactly H_RES*V_RES consecutive wr_en cycles, with no gaps.
- clear_start during CLEAR is ignored; there is no restart and no queuing.
- Asserting rst mid-clear or mid-write immediately forces all outputs and state to their reset values. The partial clear is abandoned.
- The pointer is not modified by a clear.

Optional Feature:
- Macro: FB_WR_DROP_CNT_EN
- When defined:
  - Extra output drop_count [15:0] counts out-of-range accepted requests and saturates at 0xFFFF.
  - Extra input drop_clr [1] synchronously zeroes the count; clearing wins over a simultaneous increment.
  - Reset value of drop_count is 0.
- When undefined: neither port exists and no counter logic is built.

Test Plan:
- Reset, then requester 0 sends x=3, y=2, data=0xAA → req_ready[0]=1 that cycle; next cycle wr_en=1, wr_addr=1283, wr_data=0xAA.
- Both requesters hold valid for 6 cycles → grants alternate 0,1,0,1,0,1 with one wr_en every cycle; a single active requester is granted every cycle.
- Requester 1 sends x=640, y=0 → req_ready[1]=1, pointer advances, wr_en stays 0. With FB_WR_DROP_CNT_EN defined, drop_count goes 0→1.
- clear_start with clear_value=0x10 while requester 0 is valid → req_ready=0 for 307201 cycles. Bench then checks:
  - 307200 consecutive writes of 0x10 to addresses 0..307199
  - clear_done and busy-fall both on the addr-307199 cycle
  - requester 0 granted on the cycle after clear_done
- Second clear_start pulse issued mid-clear → ignored; total clear write count is still 307200.
- rst asserted at clear address 1000 → wr_en, busy and clear_done drop to 0 immediately; after release, a new request writes normally.
